// File: rtl/traffic_pkg.sv
// Light codes and phase encoding shared by the traffic controller and its
// consumer-side sequence monitor.
package traffic_pkg;

  localparam logic [2:0] RED    = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b100;

  typedef enum logic [1:0] {
    UNKNOWN  = 2'd0,
    GREEN_S  = 2'd1,
    YELLOW_S = 2'd2,
    RED_S    = 2'd3
  } phase_e;

  // Any code that is not exactly one of the three lamps maps to UNKNOWN.
  function automatic phase_e code_to_phase(input logic [2:0] code);
    phase_e p;
    case (code)
      GREEN:   p = GREEN_S;
      YELLOW:  p = YELLOW_S;
      RED:     p = RED_S;
      default: p = UNKNOWN;
    endcase
    return p;
  endfunction

  function automatic phase_e legal_next(input phase_e p);
    phase_e n;
    case (p)
      GREEN_S:  n = YELLOW_S;
      YELLOW_S: n = RED_S;
      RED_S:    n = GREEN_S;
      default:  n = UNKNOWN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/light_sequence_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear and load-1; used to measure
// how many cycles the current light phase has been held.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)                          count_d = '0;
    else if (load_i)                    count_d = ONE;
    else if (inc_i && (count_q != '1))  count_d = count_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/light_sequence_monitor.sv
// Passive monitor of the one-hot lights bus: tracks the phase, flags illegal
// codes, orders and short dwells, and grants pedestrian walk during RED.
module light_sequence_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int MIN_RED    = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       lights,
  input  logic             pedestrian_button,
  input  logic             err_clear,
  output logic             walk,
  output logic             ped_pending,
  output logic             err_code,
  output logic             err_sequence,
  output logic             err_dwell,
  output logic [CNT_W-1:0] cycle_count,
  output phase_e           phase_dbg,
  output logic [CNT_W-1:0] dwell_dbg
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // No handshake: lights is sampled every cycle and nothing is ever stalled.
  phase_e           phase_q, phase_d, code_phase;
  logic [CNT_W-1:0] dwell, min_dwell;
  logic             code_valid, phase_change, grant;
  logic             ev_code, ev_seq, ev_dwell, red_to_green;
  logic             walk_q, walk_d, ped_q, ped_d;
  logic             err_code_q, err_code_d, err_seq_q, err_seq_d;
  logic             err_dwell_q, err_dwell_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;

  sat_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (!code_valid),
    .load_i  (code_valid && (code_phase != phase_q)),
    .inc_i   (code_valid && (code_phase == phase_q)),
    .count_o (dwell)
  );

  always_comb begin
    code_phase   = code_to_phase(lights);
    code_valid   = (code_phase != UNKNOWN);
    phase_d      = code_phase;
    min_dwell    = '0;
    case (phase_q)
      GREEN_S:  min_dwell = CNT_W'(MIN_GREEN);
      YELLOW_S: min_dwell = CNT_W'(MIN_YELLOW);
      RED_S:    min_dwell = CNT_W'(MIN_RED);
      default:  min_dwell = '0;
    endcase
    // Entry from UNKNOWN is never a "change": neither order nor dwell is checked.
    phase_change = (phase_q != UNKNOWN) && (code_phase != phase_q);
    ev_code      = !code_valid;
    ev_seq       = phase_change && code_valid && (code_phase != legal_next(phase_q));
    ev_dwell     = phase_change && (dwell < min_dwell);
    red_to_green = (phase_q == RED_S) && (code_phase == GREEN_S);
    grant        = ped_q && (phase_q == RED_S) && (code_phase == RED_S);

    walk_d       = (walk_q || grant) && (code_phase == RED_S);
    ped_d        = grant ? 1'b0 : (ped_q || (pedestrian_button && !walk_q));
    err_code_d   = (err_code_q  && !err_clear) || ev_code;
    err_seq_d    = (err_seq_q   && !err_clear) || ev_seq;
    err_dwell_d  = (err_dwell_q && !err_clear) || ev_dwell;
    cycle_d      = red_to_green ? cycle_q + ONE : cycle_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q     <= UNKNOWN;
      walk_q      <= 1'b0;
      ped_q       <= 1'b0;
      err_code_q  <= 1'b0;
      err_seq_q   <= 1'b0;
      err_dwell_q <= 1'b0;
      cycle_q     <= '0;
    end else begin
      phase_q     <= phase_d;
      walk_q      <= walk_d;
      ped_q       <= ped_d;
      err_code_q  <= err_code_d;
      err_seq_q   <= err_seq_d;
      err_dwell_q <= err_dwell_d;
      cycle_q     <= cycle_d;
    end
  end

  assign walk         = walk_q;
  assign ped_pending  = ped_q;
  assign err_code     = err_code_q;
  assign err_sequence = err_seq_q;
  assign err_dwell    = err_dwell_q;
  assign cycle_count  = cycle_q;
  assign phase_dbg    = phase_q;
  assign dwell_dbg    = dwell;

endmodule

// File: tb/tb_light_sequence_monitor.sv
// Bench for light_sequence_monitor: directed vector table, saturation/wrap
// sequences, and randomized traffic against a run-length reference model.
module tb_light_sequence_monitor;
  import traffic_pkg::*;

  localparam int CNT_W      = 8;
  localparam int MIN_GREEN  = 4;
  localparam int MIN_YELLOW = 2;
  localparam int MIN_RED    = 2;
  localparam int OUT_W      = 5 + CNT_W;
  localparam int SAT        = (1 << CNT_W) - 1;

  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b100;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [2:0]       lights = 3'b000;
  logic             pedestrian_button = 1'b0;
  logic             err_clear = 1'b0;
  logic             walk, ped_pending, err_code, err_sequence, err_dwell;
  logic [CNT_W-1:0] cycle_count, dwell_dbg;
  phase_e           phase_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int step_no  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  light_sequence_monitor #(
    .MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW), .MIN_RED(MIN_RED), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .lights(lights),
    .pedestrian_button(pedestrian_button), .err_clear(err_clear),
    .walk(walk), .ped_pending(ped_pending), .err_code(err_code),
    .err_sequence(err_sequence), .err_dwell(err_dwell),
    .cycle_count(cycle_count), .phase_dbg(phase_dbg), .dwell_dbg(dwell_dbg)
  );

  // ---------------- reference model ----------------
  // Phase as 0=GREEN,1=YELLOW,2=RED,-1=unknown; legal successor is (p+1)%3.
  int  m_phase, m_run, m_cc;
  bit  m_walk, m_ped, m_ec, m_es, m_ed;
  logic [OUT_W-1:0] exp_q[$];

  function automatic int phase_of(input logic [2:0] l);
    if (l == G) return 0;
    if (l == Y) return 1;
    if (l == R) return 2;
    return -1;
  endfunction

  function automatic logic [2:0] code_of(input int p);
    logic [2:0] c;
    c = (p == 0) ? G : (p == 1) ? Y : R;
    return c;
  endfunction

  function automatic int min_of(input int p);
    return (p == 0) ? MIN_GREEN : (p == 1) ? MIN_YELLOW : MIN_RED;
  endfunction

  task automatic model_reset();
    m_phase = -1; m_run = 0; m_cc = 0;
    m_walk = 0; m_ped = 0; m_ec = 0; m_es = 0; m_ed = 0;
  endtask

  task automatic model_update(input logic rn, input logic [2:0] l,
                              input logic b, input logic c);
    int p;
    bit ev_c, ev_s, ev_d, grant, nw, np;
    logic [CNT_W-1:0] cc_v;
    if (!rn) begin
      model_reset();
    end else begin
      p     = phase_of(l);
      ev_c  = (p < 0);
      ev_s  = (m_phase >= 0) && (p >= 0) && (p != m_phase) && (p != (m_phase + 1) % 3);
      ev_d  = (m_phase >= 0) && (p != m_phase) && (m_run < min_of(m_phase));
      grant = m_ped && (m_phase == 2) && (p == 2);
      nw    = (m_walk || grant) && (p == 2);
      np    = grant ? 1'b0 : (m_ped || (b && !m_walk));
      if (m_phase == 2 && p == 0) m_cc = (m_cc + 1) % (SAT + 1);
      if (p < 0)             m_run = 0;
      else if (p == m_phase) m_run = (m_run < SAT) ? m_run + 1 : SAT;
      else                   m_run = 1;
      m_ec = (m_ec && !c) || ev_c;
      m_es = (m_es && !c) || ev_s;
      m_ed = (m_ed && !c) || ev_d;
      m_walk = nw; m_ped = np; m_phase = p;
    end
    cc_v = CNT_W'(m_cc);
    exp_q.push_back({m_walk, m_ped, m_ec, m_es, m_ed, cc_v});
  endtask

  // ---------------- scoreboard ----------------
  function automatic logic [OUT_W-1:0] dut_vec();
    return {walk, ped_pending, err_code, err_sequence, err_dwell, cycle_count};
  endfunction

  task automatic check_model();
    logic [OUT_W-1:0] exp;
    exp = exp_q.pop_front();
    n_checks++;
    if (dut_vec() !== exp) begin
      n_fail++;
      $display("FAIL model_outputs step %0d: got w/p/ec/es/ed/cc=%b expected %b",
               step_no, dut_vec(), exp);
    end
    n_checks++;
    if (dwell_dbg !== CNT_W'(m_run)) begin
      n_fail++;
      $display("FAIL model_dwell step %0d: got %0d expected %0d", step_no, dwell_dbg, m_run);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rn, input logic [2:0] l, input logic b, input logic c);
    reset_n = rn; lights = l; pedestrian_button = b; err_clear = c;
    @(posedge clk);
    model_update(rn, l, b, c);
    #1;
    step_no++;
    check_model();
  endtask

  task automatic hold(input logic [2:0] l, input int n);
    for (int i = 0; i < n; i++) step(1'b1, l, 1'b0, 1'b0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic             rn;
    logic [2:0]       l;
    logic             b;
    logic             c;
    logic [OUT_W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rn, input logic [2:0] l, input logic b,
                              input logic c, input logic w, input logic p,
                              input logic ec, input logic es, input logic ed, input int cc);
    vec_t v;
    logic [CNT_W-1:0] ccv;
    ccv   = CNT_W'(cc);
    v.rn  = rn; v.l = l; v.b = b; v.c = c;
    v.exp = {w, p, ec, es, ed, ccv};
    return v;
  endfunction

  task automatic fill_table();
    // reset
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0));
    // clean cycle G4 Y2 R2 G
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, G, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(1, Y, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(1, R, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, G, 0, 0, 0, 0, 0, 0, 0, 1));
    // short GREEN (3 samples) then YELLOW, then clear
    vecs.push_back(mk(1, G, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, G, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, Y, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, Y, 0, 1, 0, 0, 0, 0, 0, 1));
    // legal into RED/GREEN, then illegal GREEN->RED, bad code, re-entry with clear
    vecs.push_back(mk(1, R, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, R, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, G, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, R, 0, 0, 0, 0, 0, 1, 1, 2));
    vecs.push_back(mk(1, 3'b011, 0, 0, 0, 0, 1, 1, 1, 2));
    vecs.push_back(mk(1, G, 0, 1, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, G, 0, 0, 0, 0, 0, 0, 0, 2));
    // button during GREEN, walk through RED
    vecs.push_back(mk(1, G, 1, 0, 0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, G, 0, 0, 0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, Y, 0, 0, 0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, Y, 0, 0, 0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, R, 0, 0, 0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, R, 0, 0, 1, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, R, 1, 0, 1, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, G, 0, 0, 0, 0, 0, 0, 0, 3));
    // second walk, then reset mid-RED with a press
    vecs.push_back(mk(1, G, 1, 0, 0, 1, 0, 0, 0, 3));
    vecs.push_back(mk(1, G, 0, 0, 0, 1, 0, 0, 0, 3));
    vecs.push_back(mk(1, G, 0, 0, 0, 1, 0, 0, 0, 3));
    vecs.push_back(mk(1, Y, 0, 0, 0, 1, 0, 0, 0, 3));
    vecs.push_back(mk(1, Y, 0, 0, 0, 1, 0, 0, 0, 3));
    vecs.push_back(mk(1, R, 0, 0, 0, 1, 0, 0, 0, 3));
    vecs.push_back(mk(1, R, 0, 0, 1, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, R, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, R, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, R, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, G, 0, 0, 0, 0, 0, 0, 0, 1));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int gen_p, gen_left;
    logic [2:0] l;
    model_reset();
    fill_table();

    foreach (vecs[i]) begin
      step(vecs[i].rn, vecs[i].l, vecs[i].b, vecs[i].c);
      n_checks++;
      if (dut_vec() !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL table_row %0d: got w/p/ec/es/ed/cc=%b expected %b",
                 i, dut_vec(), vecs[i].exp);
      end
      if (i == 0) begin
        n_checks++;
        if (phase_dbg !== UNKNOWN || dwell_dbg !== '0) begin
          n_fail++;
          $display("FAIL reset_phase: got phase=%0d dwell=%0d expected 0/0",
                   phase_dbg, dwell_dbg);
        end
      end
    end

    // long RED hold: dwell saturates, leaving it is not a short dwell
    step(1'b0, R, 1'b0, 1'b0);
    hold(R, 300);
    n_checks++;
    if (dwell_dbg !== CNT_W'(SAT) || err_dwell !== 1'b0) begin
      n_fail++;
      $display("FAIL dwell_saturate: got dwell=%0d err_dwell=%b expected %0d/0",
               dwell_dbg, err_dwell, SAT);
    end

    // 256 legal RED->GREEN transitions wrap the cycle counter
    for (int k = 0; k < 256; k++) begin
      hold(G, 4); hold(Y, 2); hold(R, 2);
    end
    n_checks++;
    if (cycle_count !== '0 || err_dwell || err_sequence || err_code) begin
      n_fail++;
      $display("FAIL cycle_wrap: got cc=%0d errs=%b%b%b expected 0/000",
               cycle_count, err_code, err_sequence, err_dwell);
    end

    // randomized traffic: mostly legal order with random dwell, some noise
    step(1'b0, 3'b000, 1'b0, 1'b0);
    gen_p = 2; gen_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        l = 3'($urandom_range(0, 7));
      end else begin
        if (gen_left == 0) begin
          gen_p    = (gen_p + 1) % 3;
          gen_left = $urandom_range(1, 6);
        end
        gen_left--;
        l = code_of(gen_p);
      end
      step($urandom_range(0, 199) != 0, l,
           $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
